// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC register, byte-wide combinational instruction memory
// interface and a 2-entry {instr, pc} buffer toward the decoder.
module instruction_fetch #(
    parameter int                    IMEM_DEPTH = 4,
    parameter logic [IMEM_DEPTH*8-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    halt,
    input  logic                    redirect_valid,
    input  logic [IMEM_DEPTH*8-1:0] redirect_pc,
    output logic [IMEM_DEPTH*8-1:0] imem_addr,
    input  logic [7:0]              imem_data,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [7:0]              instr,
    output logic [IMEM_DEPTH*8-1:0] instr_pc,
    output logic                    busy
);
    localparam int AW = IMEM_DEPTH * 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        FULL   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [1:0]      count_q, count_d;
    logic [7:0]      instr0_q, instr0_d, instr1_q, instr1_d;
    logic [AW-1:0]   pc0_q, pc0_d, pc1_q, pc1_d;

    logic            pop;
    logic            push;
    logic [1:0]      wr_idx;

    assign pop         = (count_q != 2'd0) && instr_ready;
    assign imem_addr   = pc_q;
    assign instr_valid = (count_q != 2'd0);
    assign instr       = instr0_q;
    assign instr_pc    = pc0_q;
    assign busy        = (state_q == FETCH) || (state_q == FULL);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        push     = 1'b0;
        wr_idx   = 2'd0;

        if (redirect_valid) begin
            // Flush wins over everything; an accompanying pop is simply absorbed.
            count_d = 2'd0;
            pc_d    = redirect_pc;
            if (state_q == FETCH || state_q == FULL)
                state_d = FETCH;
        end else begin
            unique case (state_q)
                IDLE, HALTED: begin
                    if (start)
                        state_d = FETCH;
                end
                FETCH: begin
                    if (halt)
                        state_d = HALTED;
                    else
                        push = (count_q < 2'd2) || pop;
                end
                FULL: begin
                    if (halt)
                        state_d = HALTED;
                    else if (pop)
                        state_d = FETCH;
                end
                default: state_d = IDLE;
            endcase

            if (pop) begin
                instr0_d = instr1_q;
                pc0_d    = pc1_q;
            end
            if (push) begin
                wr_idx = count_q - {1'b0, pop};
                if (wr_idx == 2'd0) begin
                    instr0_d = imem_data;
                    pc0_d    = pc_q;
                end else begin
                    instr1_d = imem_data;
                    pc1_d    = pc_q;
                end
                pc_d = pc_q + 1'b1;
            end

            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (state_q == FETCH && !halt && count_d == 2'd2)
                state_d = FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
        end
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001: The block SHALL have parameter IMEM_DEPTH, default 4, which sets the address width AW = IMEM_DEPTH*8 bits (32 by default).
REQ-002: The block SHALL have parameter RESET_PC, default 0, which is the PC loaded at reset.
REQ-003: The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004: The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-005: The block SHALL have port start, input, 1 bit, a one-cycle pulse that begins or resumes fetching.
REQ-006: The block SHALL have port halt, input, 1 bit, a one-cycle pulse that stops issuing new fetches.
REQ-007: The block SHALL have port redirect_valid, input, 1 bit, a branch/jump request.
REQ-008: The block SHALL have port redirect_pc, input, AW bits, the new PC, sampled when redirect_valid=1.
REQ-009: The block SHALL have port imem_addr, output, AW bits, the address driven to instruction memory.
REQ-010: The block SHALL have port imem_data, input, 8 bits, the instruction byte; it is combinational from imem_addr, valid in the same cycle.
REQ-011: The block SHALL have port instr_valid, output, 1 bit, meaning the head of the buffer holds an instruction.
REQ-012: The block SHALL have port instr_ready, input, 1 bit, meaning the decoder accepts the head instruction.
REQ-013: The block SHALL have port instr, output, 8 bits, the head instruction byte.
REQ-014: The block SHALL have port instr_pc, output, AW bits, the address the head instruction was fetched from.
REQ-015: The block SHALL have port busy, output, 1 bit, high in state FETCH or FULL.

Function
REQ-016: The block SHALL implement FSM states IDLE, FETCH, FULL and HALTED, encoded in a registered state variable.
REQ-017: imem_addr SHALL equal the PC register at all times, with no combinational path from inputs to imem_addr.
REQ-018: The block SHALL contain a 2-entry FIFO of {instr, pc}; instr_valid = (count != 0); instr and instr_pc are driven from the head entry.
REQ-019: A pop SHALL occur when instr_valid=1 and instr_ready=1 in the same cycle.
REQ-020: A push SHALL occur in state FETCH when (count < 2 or a pop occurs this cycle) and redirect_valid=0; a push stores {imem_data, PC} and sets PC <= PC+1.
REQ-021: PC increment SHALL wrap modulo 2^AW (all-ones -> 0) without flagging an error.
REQ-022: Transitions from IDLE or HALTED SHALL be: start=1 -> FETCH; otherwise hold.
REQ-023: The transition from FETCH SHALL be: halt=1 -> HALTED with no push in that cycle; otherwise, if count becomes 2 after push/pop -> FULL.
REQ-024: The transition from FULL SHALL be: halt=1 -> HALTED; otherwise, on a pop -> FETCH; no push occurs in FULL.
REQ-025: Buffered entries SHALL continue to drain through the handshake in HALTED and IDLE.
REQ-026: redirect_valid=1 SHALL take priority over start, halt, push and FIFO hold: the FIFO is flushed (count=0), PC <= redirect_pc, and the state goes to FETCH if it was FETCH or FULL, otherwise the state is unchanged.
REQ-027: A pop coincident with a redirect SHALL be a completed handshake, and the flush still applies.
REQ-028: After a redirect, instr_valid SHALL be 0 in the next cycle, and the first instruction from redirect_pc SHALL appear at the earliest one cycle later.
REQ-029: When start and halt are asserted in the same cycle, halt SHALL win in FETCH/FULL and start SHALL win in IDLE/HALTED.
REQ-030: Fetch latency SHALL be such that an instruction pushed in cycle N is visible on instr/instr_valid in cycle N+1.
REQ-031: Sustained throughput SHALL be 1 instruction/cycle while instr_ready=1.
REQ-032: instr and instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.

Reset
REQ-033: When reset=1 at a clock edge, the block SHALL set state IDLE, PC=RESET_PC, count=0, instr_valid=0, busy=0, instr=0 and instr_pc=0; reset overrides all other inputs including redirect.
REQ-034: Reset asserted mid-operation SHALL discard buffered instructions, with no stale entries visible after reset is released.

Verification
REQ-035: Scenario: reset, then start with instr_ready=1 over memory 0x10,0x11,0x12 -> instr 0x10/pc0, 0x11/pc1 and 0x12/pc2 on consecutive cycles, first one the cycle after the first push.
REQ-036: Scenario: instr_ready=0 after start -> two pushes then state FULL; PC=2 holds, instr=0x10 stable, busy=1; raising ready -> pops resume and no byte is lost or duplicated.
REQ-037: Scenario: redirect_valid with redirect_pc=0x20 while FULL -> next cycle instr_valid=0 and imem_addr=0x20; the following instr_pc is 0x20.
REQ-038: Scenario: halt while FETCH with 1 entry buffered -> no further pushes and state HALTED; the entry drains; then start -> fetching resumes at the held PC.
REQ-039: Scenario: PC preloaded to 0xFFFFFFFF via redirect -> entries carry instr_pc 0xFFFFFFFF then 0x00000000.
REQ-040: Scenario: reset asserted with 2 entries buffered -> the next cycle shows instr_valid=0, state IDLE and imem_addr=RESET_PC.
